// File: rtl/snl_pkg.sv
// Shared types and constants for the snakes-and-ladders turn engine:
// FSM state encoding, field widths and the board's jump table.
package snl_pkg;

  localparam int POS_W    = 7;
  localparam int WINNER_W = 4;
  localparam logic [WINNER_W-1:0] WINNER_NONE = '0;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_STEP,
    ST_JUMP,
    ST_CHECK,
    ST_WON
  } state_e;

  typedef struct packed {
    logic [POS_W-1:0] from_sq;
    logic [POS_W-1:0] to_sq;
  } jump_t;

  localparam int NUM_JUMPS = 12;

  // Ladders first (upward), then snakes (downward).
  localparam jump_t JUMPS [NUM_JUMPS] = '{
    '{7'd4,  7'd14}, '{7'd9,  7'd31}, '{7'd28, 7'd84},
    '{7'd51, 7'd67}, '{7'd71, 7'd91}, '{7'd80, 7'd100},
    '{7'd17, 7'd7},  '{7'd54, 7'd34}, '{7'd62, 7'd19},
    '{7'd87, 7'd24}, '{7'd95, 7'd75}, '{7'd98, 7'd79}
  };

endpackage

// File: rtl/snl_turn_engine_if.sv
// Dice-roll handshake between the roll source and the turn engine.
interface snl_turn_engine_if;
  logic       roll_valid;
  logic [2:0] roll_value;
  logic       roll_ready;

  modport master (output roll_valid, output roll_value, input  roll_ready);
  modport slave  (input  roll_valid, input  roll_value, output roll_ready);
endinterface

// File: rtl/snl_jump_table.sv
// Combinational snake/ladder lookup; squares not in the table map to themselves.
module snl_jump_table
  import snl_pkg::*;
(
  input  logic [POS_W-1:0] square,
  output logic [POS_W-1:0] dest
);

  always_comb begin
    // NOTE: assign a default before any conditional so every path drives dest and no latch is inferred.
    dest = square;
    for (int i = 0; i < NUM_JUMPS; i++) begin
      if (square == JUMPS[i].from_sq) dest = JUMPS[i].to_sq;
    end
  end

endmodule

// File: rtl/snl_turn_engine.sv
// Snakes-and-ladders turn engine: accepts a roll, moves the current player,
// applies one jump, detects the win and rotates the turn.
module snl_turn_engine
  import snl_pkg::*;
#(
  parameter int NUM_PLAYERS  = 4,
  parameter int BOARD_LAST   = 100,
  parameter int EXACT_FINISH = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  new_game,
  snl_turn_engine_if.slave      roll,
  output logic [4*POS_W-1:0]    positions,
  output logic [1:0]            current_player,
  output logic                  move_done,
  output logic                  roll_error,
  output logic [WINNER_W-1:0]   winner
);

  localparam logic [POS_W-1:0] LAST7       = POS_W'(BOARD_LAST);
  localparam logic [POS_W:0]   LAST8       = (POS_W+1)'(BOARD_LAST);
  localparam logic [1:0]       LAST_PLAYER = 2'(NUM_PLAYERS - 1);

  state_e                state_q, state_d;
  logic [2:0]            roll_q, roll_d;
  logic [POS_W-1:0]      tent_q, tent_d;
  logic [POS_W-1:0]      pos_q [4];
  logic [POS_W-1:0]      pos_d [4];
  logic [1:0]            cur_q, cur_d;
  logic [WINNER_W-1:0]   winner_q, winner_d;
  logic                  move_done_q, move_done_d;
  logic                  roll_error_q, roll_error_d;

  logic                  accept;
  logic                  roll_legal;
  logic [POS_W-1:0]      cur_pos;
  logic [POS_W:0]        sum;
  logic [POS_W-1:0]      jump_dest;

  assign accept     = (state_q == ST_WAIT) && roll.roll_valid;
  assign roll_legal = (roll.roll_value != 3'd0) && (roll.roll_value != 3'd7);
  assign cur_pos    = pos_q[cur_q];
  // Widened by one bit so an overshoot past the last square is detected, never wrapped.
  assign sum        = {1'b0, cur_pos} + (POS_W+1)'(roll_q);

  snl_jump_table u_jump_table (
    .square (tent_q),
    .dest   (jump_dest)
  );

  // State register
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) state_q <= ST_WAIT;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (new_game) begin
      state_d = ST_WAIT;
    end else begin
      unique case (state_q)
        ST_WAIT:  if (accept && roll_legal) state_d = ST_STEP;
        ST_STEP:  state_d = ST_JUMP;
        ST_JUMP:  state_d = ST_CHECK;
        ST_CHECK: state_d = (cur_pos == LAST7) ? ST_WON : ST_WAIT;
        ST_WON:   state_d = ST_WON;
        default:  state_d = ST_WAIT;
      endcase
    end
  end

  // Datapath next values; new_game clears everything so an in-flight move is dropped whole.
  always_comb begin
    roll_d       = roll_q;
    tent_d       = tent_q;
    pos_d        = pos_q;
    cur_d        = cur_q;
    winner_d     = winner_q;
    move_done_d  = 1'b0;
    roll_error_d = 1'b0;
    if (new_game) begin
      roll_d   = '0;
      tent_d   = '0;
      pos_d    = '{default: '0};
      cur_d    = '0;
      winner_d = WINNER_NONE;
    end else begin
      unique case (state_q)
        ST_WAIT: begin
          if (accept) begin
            if (roll_legal) roll_d = roll.roll_value;
            else            roll_error_d = 1'b1;
          end
        end
        ST_STEP: begin
          if (sum > LAST8) tent_d = (EXACT_FINISH != 0) ? cur_pos : LAST7;
          else             tent_d = sum[POS_W-1:0];
        end
        ST_JUMP: pos_d[cur_q] = jump_dest;
        ST_CHECK: begin
          if (cur_pos == LAST7) begin
            winner_d = WINNER_W'(cur_q) + WINNER_W'(1);
          end else begin
            move_done_d = 1'b1;
            cur_d       = (cur_q == LAST_PLAYER) ? 2'd0 : cur_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      roll_q       <= '0;
      tent_q       <= '0;
      // NOTE: the position array is a handful of flops, not a RAM, so it is reset explicitly.
      pos_q        <= '{default: '0};
      cur_q        <= '0;
      winner_q     <= WINNER_NONE;
      move_done_q  <= 1'b0;
      roll_error_q <= 1'b0;
    end else begin
      roll_q       <= roll_d;
      tent_q       <= tent_d;
      pos_q        <= pos_d;
      cur_q        <= cur_d;
      winner_q     <= winner_d;
      move_done_q  <= move_done_d;
      roll_error_q <= roll_error_d;
    end
  end

  // Output decode
  always_comb begin
    roll.roll_ready = (state_q == ST_WAIT);
  end

  assign current_player = cur_q;
  assign move_done      = move_done_q;
  assign roll_error     = roll_error_q;
  assign winner         = winner_q;

  for (genvar p = 0; p < 4; p++) begin : g_pos
    if (p < NUM_PLAYERS) begin : g_used
      assign positions[p*POS_W +: POS_W] = pos_q[p];
    end else begin : g_unused
      assign positions[p*POS_W +: POS_W] = '0;
    end
  end

endmodule

// File: tb/tb_snl_turn_engine.sv
// Scoreboard bench: two engines (4 players and 2 players) driven by directed
// roll tables; expected turn outcomes are queued and checked by monitors.
module tb_snl_turn_engine;
  import snl_pkg::*;

  logic clock = 1'b0;
  logic reset;
  logic ng_a, ng_b;

  snl_turn_engine_if if_a ();
  snl_turn_engine_if if_b ();

  logic [27:0] pos_a, pos_b;
  logic [1:0]  cur_a, cur_b;
  logic        md_a, md_b, re_a, re_b;
  logic [3:0]  win_a, win_b;

  snl_turn_engine #(.NUM_PLAYERS(4), .BOARD_LAST(100), .EXACT_FINISH(1)) dut_a (
    .clock          (clock),
    .reset          (reset),
    .new_game       (ng_a),
    .roll           (if_a),
    .positions      (pos_a),
    .current_player (cur_a),
    .move_done      (md_a),
    .roll_error     (re_a),
    .winner         (win_a)
  );

  snl_turn_engine #(.NUM_PLAYERS(2), .BOARD_LAST(100), .EXACT_FINISH(1)) dut_b (
    .clock          (clock),
    .reset          (reset),
    .new_game       (ng_b),
    .roll           (if_b),
    .positions      (pos_b),
    .current_player (cur_b),
    .move_done      (md_b),
    .roll_error     (re_b),
    .winner         (win_b)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        md;
    logic        re;
    logic [27:0] pos;
    logic [1:0]  cur;
    logic [3:0]  win;
  } evt_t;

  evt_t q_a[$];
  evt_t q_b[$];
  evt_t e_a, e_b;

  int n_pass  = 0;
  int n_total = 0;

  int mpos [2][4];
  int mcur [2];
  int mwin [2];

  // Game A: 4 players. Row value 7 is an illegal roll (expected square unused).
  int rolls_a [32] = '{4, 6, 3, 1,   6, 6, 1, 2,   7,
                       2, 5, 6, 1,   6, 2, 6, 6,   6, 6, 2, 6,
                       3, 6, 6, 2,   4, 6, 4, 6,   5, 2, 6};
  int exp_a   [32] = '{14, 6, 3, 1,  20, 12, 14, 3, 0,
                       22, 7, 20, 14, 84, 31, 26, 20, 90, 37, 84, 26,
                       93, 43, 90, 84, 97, 49, 94, 90, 97, 67, 100};
  // Game B: 2 players; ends with 75 + 5 -> 80 -> ladder to 100.
  int rolls_b [13] = '{4, 3, 6, 1, 6, 6, 2, 6, 6, 2, 5, 6, 5};
  int exp_b   [13] = '{14, 3, 20, 14, 26, 20, 84, 26, 90, 84, 75, 90, 100};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int num_players(input int s);
    return (s == 0) ? 4 : 2;
  endfunction

  function automatic logic [27:0] model_vec(input int s);
    logic [27:0] v;
    for (int p = 0; p < 4; p++) v[p*7 +: 7] = 7'(mpos[s][p]);
    return v;
  endfunction

  function automatic evt_t model_evt(input int s, input logic md, input logic re);
    evt_t e;
    e.md  = md;
    e.re  = re;
    e.pos = model_vec(s);
    e.cur = 2'(mcur[s]);
    e.win = 4'(mwin[s]);
    return e;
  endfunction

  function automatic logic dut_ready(input int s);
    return (s == 0) ? if_a.roll_ready : if_b.roll_ready;
  endfunction

  task automatic drive(input int s, input logic v, input logic [2:0] val);
    if (s == 0) begin if_a.roll_valid = v; if_a.roll_value = val; end
    else        begin if_b.roll_valid = v; if_b.roll_value = val; end
  endtask

  task automatic model_clear(input int s);
    for (int p = 0; p < 4; p++) mpos[s][p] = 0;
    mcur[s] = 0;
    mwin[s] = 0;
  endtask

  task automatic check_state(input int s, input string tag, input logic exp_ready);
    if (s == 0) begin
      check({tag, "_pos"},    pos_a, model_vec(0));
      check({tag, "_cur"},    cur_a, mcur[0]);
      check({tag, "_winner"}, win_a, mwin[0]);
    end else begin
      check({tag, "_pos"},    pos_b, model_vec(1));
      check({tag, "_cur"},    cur_b, mcur[1]);
      check({tag, "_winner"}, win_b, mwin[1]);
    end
    check({tag, "_ready"}, dut_ready(s), exp_ready);
  endtask

  task automatic compare_evt(input string tag, input evt_t e, input logic md, input logic re,
                             input logic [27:0] pos, input logic [1:0] cur, input logic [3:0] win);
    check({tag, "_move_done"},  md,  e.md);
    check({tag, "_roll_error"}, re,  e.re);
    check({tag, "_positions"},  pos, e.pos);
    check({tag, "_cur"},        cur, e.cur);
    check({tag, "_winner"},     win, e.win);
  endtask

  // One roll for engine s; exp_pos is the hand-computed landing square.
  task automatic do_roll(input int s, input logic [2:0] v, input int exp_pos);
    int cycles = 0;
    int c;
    @(negedge clock);
    while (dut_ready(s) !== 1'b1 && cycles < 20) begin
      @(negedge clock);
      cycles++;
    end
    check("ready_before_roll", dut_ready(s), 1'b1);
    drive(s, 1'b1, v);
    if (v == 3'd0 || v == 3'd7) begin
      if (s == 0) q_a.push_back(model_evt(0, 1'b0, 1'b1));
      else        q_b.push_back(model_evt(1, 1'b0, 1'b1));
      @(posedge clock);
      #1 drive(s, 1'b0, 3'd0);
      check("ready_after_error", dut_ready(s), 1'b1);
    end else begin
      c = mcur[s];
      mpos[s][c] = exp_pos;
      if (exp_pos == 100) mwin[s] = c + 1;
      else                mcur[s] = (c + 1) % num_players(s);
      if (s == 0) q_a.push_back(model_evt(0, exp_pos != 100, 1'b0));
      else        q_b.push_back(model_evt(1, exp_pos != 100, 1'b0));
      @(posedge clock);
      #1 drive(s, 1'b0, 3'd0);
      repeat (3) @(posedge clock);
      #1 check("ready_turn_latency", dut_ready(s), exp_pos != 100);
    end
  endtask

  logic [3:0] prev_win_a = '0;
  logic [3:0] prev_win_b = '0;

  always @(negedge clock) begin
    if (reset === 1'b0 && (md_a || re_a || (win_a != 0 && prev_win_a == 0))) begin
      if (q_a.size() == 0) check("a_event_expected", q_a.size(), 1);
      else begin
        e_a = q_a.pop_front();
        compare_evt("a", e_a, md_a, re_a, pos_a, cur_a, win_a);
      end
    end
    prev_win_a = win_a;
  end

  always @(negedge clock) begin
    if (reset === 1'b0 && (md_b || re_b || (win_b != 0 && prev_win_b == 0))) begin
      if (q_b.size() == 0) check("b_event_expected", q_b.size(), 1);
      else begin
        e_b = q_b.pop_front();
        compare_evt("b", e_b, md_b, re_b, pos_b, cur_b, win_b);
      end
    end
    prev_win_b = win_b;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    ng_a  = 1'b0;
    ng_b  = 1'b0;
    drive(0, 1'b0, 3'd0);
    drive(1, 1'b0, 3'd0);
    model_clear(0);
    model_clear(1);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check_state(0, "reset_a", 1'b1);
    check_state(1, "reset_b", 1'b1);
    check("reset_move_done", md_a, 1'b0);
    check("reset_roll_error", re_a, 1'b0);

    // Game A: ladders, snake, illegal roll, overshoot forfeit, then player 2 wins.
    for (int i = 0; i < 32; i++) do_roll(0, 3'(rolls_a[i]), exp_a[i]);

    // Rolls presented after the win are ignored.
    @(negedge clock);
    drive(0, 1'b1, 3'd3);
    repeat (4) @(negedge clock);
    drive(0, 1'b0, 3'd0);
    check_state(0, "won_hold", 1'b0);

    @(negedge clock);
    ng_a = 1'b1;
    @(posedge clock);
    #1 ng_a = 1'b0;
    model_clear(0);
    check_state(0, "new_game_after_win", 1'b1);

    do_roll(0, 3'd4, 14);
    do_roll(0, 3'd3, 3);

    // new_game sampled while player 2's move is in JUMP.
    @(negedge clock);
    drive(0, 1'b1, 3'd2);
    @(posedge clock);
    #1 drive(0, 1'b0, 3'd0);
    @(posedge clock);
    #1 ng_a = 1'b1;
    @(posedge clock);
    #1 ng_a = 1'b0;
    model_clear(0);
    check_state(0, "abort_in_jump", 1'b1);
    repeat (6) @(posedge clock);
    #1 check_state(0, "abort_settled", 1'b1);
    do_roll(0, 3'd5, 5);

    // Game B: two players, turn wraps 0,1,0; upper slots stay zero.
    for (int i = 0; i < 13; i++) do_roll(1, 3'(rolls_b[i]), exp_b[i]);
    check("b_unused_slots", pos_b[27:14], 14'd0);

    repeat (4) @(posedge clock);
    #1;
    check("a_queue_drained", q_a.size(), 0);
    check("b_queue_drained", q_b.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/snl_turn_engine.md
Name: snl_turn_engine

Overview:
- Game-play core for the snakes-and-ladders board. Accepts one validated dice roll per turn, moves the current player, applies the snake/ladder jump, detects the win and rotates the turn.
- Produces the 4-bit `winner` code consumed by the LED celebration logic: 0 means no winner; 1..4 identify the player.
- Also exports all player positions and the current-player index for the display logic.

Parameters:
- NUM_PLAYERS, 4, number of active players; legal range 2..4.
- BOARD_LAST, 100, final square; a player reaching it wins.
- EXACT_FINISH, 1, 1 = a roll that would overshoot BOARD_LAST forfeits the move; 0 = clamp to BOARD_LAST.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- new_game  input  1  synchronous restart; same effect as reset; priority over all inputs except reset.
- roll_valid  input  1  a dice roll is presented.
- roll_value  input  3  dice value; legal 1..6.
- roll_ready  output  1  engine can accept a roll.
- positions  output  28  packed 7-bit squares; player p is at [7p+6:7p]; 0 = off board.
- current_player  output  2  index of the player whose turn it is.
- move_done  output  1  one-cycle pulse when a non-winning turn completes.
- roll_error  output  1  one-cycle pulse when an illegal roll is presented.
- winner  output  4  0 = none; p+1 = player p has won.

Behaviour:
- Reset or new_game, and the cycle after either:
  - positions = 0, current_player = 0, winner = 0, move_done = 0, roll_error = 0.
  - FSM in WAIT, so roll_ready = 1.
- FSM states: WAIT, STEP, JUMP, CHECK, WON. roll_ready = (state == WAIT); it is decoded from registered state.
- WAIT:
  - A handshake occurs when roll_valid & roll_ready at edge N.
  - If roll_value is in 1..6: latch it and go to STEP.
  - If roll_value is 0 or 7: pulse roll_error in N+1, stay in WAIT, do not advance the turn.
- STEP (cycle N+1):
  - tent = pos[cur] + roll, computed at 8 bits; no wrap.
  - If tent > BOARD_LAST: with EXACT_FINISH = 1, tent = pos[cur]; with EXACT_FINISH = 0, tent = BOARD_LAST.
  - Register tent and go to JUMP.
- JUMP (N+2): pos[cur] <= jump_lookup(tent); go to CHECK. The new position is visible from N+3.
- CHECK (N+3):
  - If pos[cur] == BOARD_LAST: winner <= cur + 1 and go to WON. winner is visible from N+4.
  - Otherwise:
    - Pulse move_done in N+4.
    - Advance current_player to cur + 1, wrapping from NUM_PLAYERS-1 to 0.
    - Go to WAIT.
- WON:
  - Hold positions, current_player and winner.
  - roll_ready = 0, so rolls are ignored.
  - Exit only via reset or new_game.
- Turn latency: 4 cycles from the accepting edge to the next roll_ready.
- Exactly one jump is applied per move; jump destinations are never chained.
- Players share squares freely; there is no collision rule.
- Unused player slots (p >= NUM_PLAYERS) always read 0.
- roll_valid held high across turns: the next roll is accepted only at the next WAIT cycle; no roll is queued.
- new_game or reset mid-turn (STEP/JUMP/CHECK): the in-flight move is discarded and nothing is partially written.

Decomposition:
- Shared package snl_pkg holds:
  - State enum.
  - Widths POS_W = 7 and WINNER_W = 4.
  - WINNER_NONE = 0.
  - The jump constants:
    - Ladders: 4→14, 9→31, 28→84, 51→67, 71→91, 80→100.
    - Snakes: 17→7, 54→34, 62→19, 87→24, 95→75, 98→79.
- Sub-module snl_jump_table: purely combinational, 7-bit square in, 7-bit destination out. Identity for squares not in the table.

Test Plan:
- Reset, then roll 4 for player 0:
  - pos0 = 14 at N+3 (ladder).
  - move_done pulses at N+4.
  - current_player = 1 and roll_ready = 1 at N+4.
- Player 1 at 12, roll 5: lands on 17, snake applied, pos1 = 7; turn passes to player 2.
- Player at 97, roll 5, EXACT_FINISH = 1: position stays 97, move_done pulses, turn passes, winner = 0.
- Player 2 at 94, roll 6: pos2 = 100 and winner = 3 at N+4. Then roll_ready = 0, and a further roll_valid with roll 3 changes nothing.
- Player at 75, roll 5: lands on 80, ladder to 100, winner asserted.
- Illegal roll 7: roll_error pulses one cycle, state and turn unchanged.
- new_game asserted in the JUMP cycle: all positions 0, winner 0, current_player 0, roll_ready = 1 next cycle.
- NUM_PLAYERS = 2: current_player sequence 0, 1, 0; positions[27:14] read 0.
